// File: rtl/gated_pulse_counter_pkg.sv
// Shared types and default widths for the gated PMT pulse counter family.
// Contents:
//   DEF_CNT_W / DEF_GATE_W : default accumulator and gate-length widths
//   DEF_CNT_SAT            : saturation value of a default-width accumulator
//   state_e                : gate FSM state encoding
package pmt_counter_pkg;

    localparam int DEF_CNT_W  = 32;
    localparam int DEF_GATE_W = 32;

    localparam logic [DEF_CNT_W-1:0] DEF_CNT_SAT = '1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        HOLD  = 2'd2
    } state_e;

endpackage

// File: rtl/gated_pulse_counter_if.sv
// Result handshake from the gated pulse counter toward the readout/FIFO stage.
// Signals:
//   cnt_data  : latched count of the last completed gate
//   cnt_sat   : the count saturated during that gate
//   cnt_valid : result available
//   cnt_ready : downstream accepts the result
// Modports: master (counter side), slave (readout side).
interface gated_pulse_counter_if
    import pmt_counter_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
);
    logic [CNT_W-1:0] cnt_data;
    logic             cnt_sat;
    logic             cnt_valid;
    logic             cnt_ready;

    modport master (output cnt_data, output cnt_sat, output cnt_valid, input cnt_ready);
    modport slave  (input cnt_data, input cnt_sat, input cnt_valid, output cnt_ready);
endinterface

// File: rtl/gated_pulse_counter_sat_counter.sv
// Saturating up-counter with synchronous clear.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : clear count and flag (wins over inc)
//   inc        : count one event
//   cnt, sat   : registered count / saturation flag
//   cnt_nxt    : value cnt takes at the next edge (includes this cycle's inc)
//   sat_nxt    : value sat takes at the next edge
// sat means at least one event was lost: it is set by an increment that
// arrives while the count already sits at all-ones. The count never wraps.
module sat_counter
    import pmt_counter_pkg::*;
#(
    parameter int W = DEF_CNT_W
)(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt,
    output logic         sat,
    output logic [W-1:0] cnt_nxt,
    output logic         sat_nxt
);
    localparam logic [W-1:0] MAX = '1;

    always_comb begin
        cnt_nxt = cnt;
        sat_nxt = sat;
        if (clr) begin
            cnt_nxt = '0;
            sat_nxt = 1'b0;
        end else if (inc) begin
            if (cnt == MAX) sat_nxt = 1'b1;
            else            cnt_nxt = cnt + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            sat <= 1'b0;
        end else begin
            cnt <= cnt_nxt;
            sat <= sat_nxt;
        end
    end
endmodule

// File: rtl/gated_pulse_counter.sv
// Counts single-cycle PMT edges inside a gate of gate_len cycles that opens
// the cycle after an accepted start, then offers the count downstream on a
// valid/ready handshake.
// Ports:
//   clk, rst_n : counting clock, asynchronous active-low reset
//   pmt_edge   : single-cycle PMT pulse edge
//   start      : single-cycle gate-open request
//   abort      : level; cancels the running gate or the pending result
//   gate_len   : gate length in cycles, sampled only on an accepted start
//   gate_out   : high during every counted gate cycle
//   busy       : high while a gate runs or a result is pending
//   start_drop : one-cycle pulse the cycle after an ignored start
//   res        : result handshake (cnt_data, cnt_sat, cnt_valid, cnt_ready)
module gated_pulse_counter
    import pmt_counter_pkg::*;
#(
    parameter int CNT_W  = DEF_CNT_W,
    parameter int GATE_W = DEF_GATE_W
)(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pmt_edge,
    input  logic              start,
    input  logic              abort,
    input  logic [GATE_W-1:0] gate_len,
    output logic              gate_out,
    output logic              busy,
    output logic              start_drop,
    gated_pulse_counter_if.master res
);
    state_e            state;
    logic [GATE_W-1:0] timer;
    logic              accept;
    logic              last;
    logic [CNT_W-1:0]  acc;
    logic              acc_sat;
    logic [CNT_W-1:0]  acc_nxt;
    logic              sat_nxt;

    // An abort in IDLE turns a coincident start into a dropped start.
    assign accept = (state == IDLE) && start && !abort && (gate_len != '0);
    // timer holds the number of gate cycles left, including the current one
    assign last   = (timer == GATE_W'(1));

    sat_counter #(.W(CNT_W)) u_acc (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (accept),
        .inc     ((state == COUNT) && pmt_edge),
        .cnt     (acc),
        .sat     (acc_sat),
        .cnt_nxt (acc_nxt),
        .sat_nxt (sat_nxt)
    );

    // The result is taken from the next-state view so the final gate cycle's
    // edge is included; the registered view is only there for other users.
    logic unused_acc;
    assign unused_acc = ^{acc, acc_sat};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            timer         <= '0;
            gate_out      <= 1'b0;
            busy          <= 1'b0;
            start_drop    <= 1'b0;
            res.cnt_data  <= '0;
            res.cnt_sat   <= 1'b0;
            res.cnt_valid <= 1'b0;
        end else begin
            start_drop <= start && !accept;
            case (state)
                IDLE: begin
                    if (accept) begin
                        state    <= COUNT;
                        timer    <= gate_len;
                        gate_out <= 1'b1;
                        busy     <= 1'b1;
                    end
                end
                COUNT: begin
                    if (abort) begin
                        state    <= IDLE;
                        gate_out <= 1'b0;
                        busy     <= 1'b0;
                    end else if (last) begin
                        state         <= HOLD;
                        gate_out      <= 1'b0;
                        res.cnt_data  <= acc_nxt;
                        res.cnt_sat   <= sat_nxt;
                        res.cnt_valid <= 1'b1;
                    end else begin
                        timer <= timer - GATE_W'(1);
                    end
                end
                HOLD: begin
                    if (abort || res.cnt_ready) begin
                        state         <= IDLE;
                        busy          <= 1'b0;
                        res.cnt_valid <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_gated_pulse_counter.sv
// Bench for gated_pulse_counter (CNT_W=4 so saturation is reachable,
// GATE_W=8 so the maximum gate length is reachable).
module tb_gated_pulse_counter;
    localparam int CW   = 4;
    localparam int GW   = 8;
    localparam int CMAX = (1 << CW) - 1;
    localparam int N    = 600;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          pmt_edge, start, abort;
    logic [GW-1:0] gate_len;
    logic          gate_out, busy, start_drop;

    gated_pulse_counter_if #(.CNT_W(CW)) rif ();

    gated_pulse_counter #(.CNT_W(CW), .GATE_W(GW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pmt_edge   (pmt_edge),
        .start      (start),
        .abort      (abort),
        .gate_len   (gate_len),
        .gate_out   (gate_out),
        .busy       (busy),
        .start_drop (start_drop),
        .res        (rif)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string nm, input int g, input int b, input int d,
                           input int v, input int data, input int sat);
        chk({nm, ".gate_out"},   int'(gate_out),      g);
        chk({nm, ".busy"},       int'(busy),          b);
        chk({nm, ".start_drop"}, int'(start_drop),    d);
        chk({nm, ".cnt_valid"},  int'(rif.cnt_valid), v);
        chk({nm, ".cnt_data"},   int'(rif.cnt_data),  data);
        chk({nm, ".cnt_sat"},    int'(rif.cnt_sat),   sat);
    endtask

    // ---------------- directed per-cycle table ----------------
    typedef struct {
        logic st, pe, ab, rdy;
        int   gl;
        logic g, b, d, v;
        int   data;
        logic sat;
    } vec_t;

    function automatic vec_t mk(input int st, input int pe, input int ab, input int rdy,
                                input int gl, input int g, input int b, input int d,
                                input int v, input int data, input int sat);
        vec_t r;
        r.st = st[0]; r.pe = pe[0]; r.ab = ab[0]; r.rdy = rdy[0]; r.gl = gl;
        r.g = g[0]; r.b = b[0]; r.d = d[0]; r.v = v[0]; r.data = data; r.sat = sat[0];
        return r;
    endfunction

    vec_t tv[20];

    // Full-gate run with pmt_edge held high and ready high.
    task automatic gate_run(input int gl, input int exp_data, input int exp_sat);
        int n = 0;
        int gates = 0;
        start = 1'b1; gate_len = GW'(gl); pmt_edge = 1'b1; rif.cnt_ready = 1'b1;
        cyc();
        start = 1'b0;
        while (!rif.cnt_valid && n < 300) begin
            if (gate_out) gates++;
            n++;
            cyc();
        end
        chk($sformatf("run%0d.latency", gl), n + 1, gl + 1);
        chk($sformatf("run%0d.gate_cycles", gl), gates, gl);
        chk($sformatf("run%0d.cnt_data", gl), int'(rif.cnt_data), exp_data);
        chk($sformatf("run%0d.cnt_sat", gl), int'(rif.cnt_sat), exp_sat);
        pmt_edge = 1'b0;
        cyc();
        chk($sformatf("run%0d.idle_valid", gl), int'(rif.cnt_valid), 0);
        chk($sformatf("run%0d.idle_busy", gl), int'(busy), 0);
    endtask

    // ---------------- random stimulus and reference ----------------
    logic r_st[N], r_pe[N], r_ab[N], r_rdy[N];
    int   r_gl[N];
    logic e_gate[N], e_busy[N], e_drop[N], e_valid[N], e_sat[N], d_set[N];
    int   e_data[N], d_val[N];

    // Reference: each accepted start owns a window of gate cycles, then a hold
    // window ending at the first abort or ready; anything else is a drop.
    task automatic build_model();
        int free_at = 0;
        int cur_d = 0;
        logic cur_s = 1'b0;
        for (int t = 0; t < N; t++) begin
            e_gate[t] = 0; e_busy[t] = 0; e_drop[t] = 0; e_valid[t] = 0;
            d_set[t] = 0; d_val[t] = 0; e_sat[t] = 0;
        end
        for (int t = 0; t < N; t++) begin
            if (!r_st[t]) continue;
            if (t >= free_at && !r_ab[t] && r_gl[t] != 0) begin
                int L = r_gl[t];
                int idle = t + L + 1;
                int cnt = 0;
                bit aborted = 0;
                for (int c = t + 1; c <= t + L && c < N; c++) begin
                    e_gate[c] = 1; e_busy[c] = 1;
                    if (r_ab[c]) begin idle = c + 1; aborted = 1; break; end
                    if (r_pe[c]) cnt++;
                end
                if (!aborted) begin
                    int h = t + L + 1;
                    if (h < N) begin
                        d_set[h] = 1;
                        d_val[h] = (cnt > CMAX) ? CMAX : cnt;
                        e_sat[h] = (cnt > CMAX);
                    end
                    while (h < N && !r_ab[h] && !r_rdy[h]) h++;
                    for (int c = t + L + 1; c <= h && c < N; c++) begin
                        e_busy[c] = 1; e_valid[c] = 1;
                    end
                    idle = h + 1;
                end
                free_at = idle;
            end else if (t + 1 < N) begin
                e_drop[t + 1] = 1;
            end
        end
        for (int t = 0; t < N; t++) begin
            if (d_set[t]) begin cur_d = d_val[t]; cur_s = e_sat[t]; end
            e_data[t] = cur_d;
            e_sat[t]  = cur_s;
        end
    endtask

    initial begin
        rst_n = 1'b1; pmt_edge = 0; start = 0; abort = 0; gate_len = '0; rif.cnt_ready = 0;
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_all("reset", 0, 0, 0, 0, 0, 0);
        @(negedge clk) rst_n = 1'b1;
        cyc();

        // gate of 10 with edges at 0,1,5,10,11; gate_len 1; gate_len 0; abort+start
        tv[0]  = mk(1,1,0,1,10, 0,0,0,0,0,0);
        tv[1]  = mk(0,1,0,1,0,  1,1,0,0,0,0);
        tv[2]  = mk(0,0,0,1,0,  1,1,0,0,0,0);
        tv[3]  = mk(0,0,0,1,0,  1,1,0,0,0,0);
        tv[4]  = mk(0,0,0,1,0,  1,1,0,0,0,0);
        tv[5]  = mk(0,1,0,1,0,  1,1,0,0,0,0);
        tv[6]  = mk(0,0,0,1,0,  1,1,0,0,0,0);
        tv[7]  = mk(0,0,0,1,0,  1,1,0,0,0,0);
        tv[8]  = mk(0,0,0,1,0,  1,1,0,0,0,0);
        tv[9]  = mk(0,0,0,1,0,  1,1,0,0,0,0);
        tv[10] = mk(0,1,0,1,0,  1,1,0,0,0,0);
        tv[11] = mk(0,1,0,1,0,  0,1,0,1,3,0);
        tv[12] = mk(1,0,0,1,1,  0,0,0,0,3,0);
        tv[13] = mk(0,1,0,1,0,  1,1,0,0,3,0);
        tv[14] = mk(0,0,0,1,0,  0,1,0,1,1,0);
        tv[15] = mk(1,0,0,1,0,  0,0,0,0,1,0);
        tv[16] = mk(0,0,0,1,0,  0,0,1,0,1,0);
        tv[17] = mk(1,0,1,1,5,  0,0,0,0,1,0);
        tv[18] = mk(0,0,0,1,0,  0,0,1,0,1,0);
        tv[19] = mk(0,0,0,1,0,  0,0,0,0,1,0);
        for (int i = 0; i < 20; i++) begin
            chk_all($sformatf("tv%0d", i), tv[i].g, tv[i].b, tv[i].d, tv[i].v, tv[i].data, tv[i].sat);
            start = tv[i].st; pmt_edge = tv[i].pe; abort = tv[i].ab;
            rif.cnt_ready = tv[i].rdy; gate_len = GW'(tv[i].gl);
            cyc();
        end
        start = 0; pmt_edge = 0; abort = 0;

        // saturation boundary and maximum gate length
        gate_run(14, 14, 0);
        gate_run(15, 15, 0);
        gate_run(16, 15, 1);
        gate_run(20, 15, 1);
        gate_run(255, 15, 1);

        // abort at gate cycle 4 of 10, new gate of 3 two cycles later
        rif.cnt_ready = 1; start = 1; gate_len = 8'd10;
        cyc();                                   // c1
        start = 0; gate_len = 8'd0;
        cyc(); cyc(); cyc();                     // c4
        abort = 1;
        chk("abort.gate_c4", int'(gate_out), 1);
        cyc();                                   // c5
        abort = 0;
        chk_all("abort.c5", 0, 0, 0, 0, 15, 1);
        cyc();                                   // c6
        start = 1; gate_len = 8'd3;
        chk("abort.valid_c6", int'(rif.cnt_valid), 0);
        cyc();                                   // c7
        start = 0; pmt_edge = 1;
        chk("abort.data_kept", int'(rif.cnt_data), 15);
        cyc(); pmt_edge = 0;                     // c8
        cyc(); pmt_edge = 1;                     // c9
        cyc(); pmt_edge = 0;                     // c10
        chk_all("abort.result", 0, 1, 0, 1, 2, 0);
        cyc();

        // result held under backpressure; starts in HOLD are dropped
        rif.cnt_ready = 0; start = 1; gate_len = 8'd3;
        cyc(); start = 0; pmt_edge = 1;          // c1
        cyc(); pmt_edge = 0;                     // c2
        cyc(); pmt_edge = 1;                     // c3
        cyc(); pmt_edge = 0;                     // c4
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("hold%0d.valid", k), int'(rif.cnt_valid), 1);
            chk($sformatf("hold%0d.data", k), int'(rif.cnt_data), 2);
            chk($sformatf("hold%0d.drop", k), int'(start_drop), (k == 2) ? 1 : 0);
            start = (k == 1);
            cyc();
        end
        rif.cnt_ready = 1; start = 1;
        chk("hold.hs_valid", int'(rif.cnt_valid), 1);
        cyc();
        start = 0;
        chk_all("hold.after", 0, 0, 1, 0, 2, 0);
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk($sformatf("hold.single%0d", k), int'(rif.cnt_valid), 0);
        end

        // asynchronous reset mid-gate
        start = 1; gate_len = 8'd10;
        cyc(); start = 0;
        cyc(); cyc();
        chk("rst_mid.busy_before", int'(busy), 1);
        #2 rst_n = 0;
        #1;
        chk_all("rst_mid", 0, 0, 0, 0, 0, 0);
        @(negedge clk) rst_n = 1;
        cyc();

        // randomized run against the window model
        for (int t = 0; t < N; t++) begin
            r_st[t]  = ($urandom_range(0, 4) == 0);
            r_pe[t]  = ($urandom_range(0, 4) != 0);
            r_ab[t]  = ($urandom_range(0, 39) == 0);
            r_rdy[t] = ($urandom_range(0, 4) < 3);
            r_gl[t]  = $urandom_range(0, 20);
        end
        build_model();
        for (int t = 0; t < N; t++) begin
            chk_all($sformatf("rnd%0d", t), e_gate[t], e_busy[t], e_drop[t], e_valid[t], e_data[t], e_sat[t]);
            start = r_st[t]; pmt_edge = r_pe[t]; abort = r_ab[t];
            rif.cnt_ready = r_rdy[t]; gate_len = GW'(r_gl[t]);
            cyc();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
